// File: rtl/shift_add_pkg.sv
// rtl/shift_add_pkg.sv - shared sizing constants for the shift-add multiplier FSM and datapath
package shift_add_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int CNT_W_DEF  = 3;
  localparam int PROD_W_DEF = 2 * WIDTH_DEF;

endpackage

// File: rtl/shift_add_acc_step.sv
// rtl/shift_add_acc_step.sv - one combinational multiply iteration: conditional add of M into ACC, then right shift of {carry, ACC, Q}
module shift_add_acc_step
  import shift_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  input  logic             add,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] sum;

  // The carry out of the add becomes the new ACC MSB, so nothing is lost in the shift
  always_comb begin
    sum      = {1'b0, acc} + (add ? {1'b0, m} : '0);
    acc_next = sum[WIDTH:1];
    q_next   = {sum[0], q[WIDTH-1:1]};
  end

endmodule

// File: rtl/shift_add_datapath.sv
// rtl/shift_add_datapath.sv - M/ACC/Q registers and iteration counter for the shift-add multiplier
// Optional SHIFT_ADD_PRODUCT_HOLD_EN adds a done-captured product hold register.
module shift_add_datapath
  import shift_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic               add,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SHIFT_ADD_PRODUCT_HOLD_EN
  input  logic               done,
`endif
  output logic               lsb,
  output logic [CNT_W-1:0]   count,
  output logic [2*WIDTH-1:0] product,
  output logic               product_valid
);

  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] q_next;
  logic             saturated;

  assign saturated = (count == CNT_W'(WIDTH));

  shift_add_acc_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_reg),
    .q        (q_reg),
    .m        (m_reg),
    .add      (add),
    .acc_next (acc_next),
    .q_next   (q_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reg   <= '0;
      acc_reg <= '0;
      q_reg   <= '0;
      count   <= '0;
    end else if (load) begin
      m_reg   <= a;
      acc_reg <= '0;
      q_reg   <= b;
      count   <= '0;
    end else if (shift && !saturated) begin
      acc_reg <= acc_next;
      q_reg   <= q_next;
      count   <= count + 1'b1;
    end
  end

  assign lsb = q_reg[0];

`ifdef SHIFT_ADD_PRODUCT_HOLD_EN
  logic [2*WIDTH-1:0] hold_reg;
  logic               hold_written;

  // Hold survives later loads so the consumer sees a stable result until the next done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_reg     <= '0;
      hold_written <= 1'b0;
    end else if (done) begin
      hold_reg     <= {acc_reg, q_reg};
      hold_written <= 1'b1;
    end
  end

  assign product       = hold_reg;
  assign product_valid = hold_written;
`else
  assign product       = {acc_reg, q_reg};
  assign product_valid = saturated;
`endif

endmodule
